spi_cmd_master: RTL



---
 rtl/spi_cmd_master.sv | 123 ++++++++++++
 1 files changed

// File: rtl/spi_cmd_master.sv
// SPI command initiator: sends a {cmd,payload} frame MSB first under SS_n and,
// for read-data commands, captures the slave's 8-bit reply from MISO.
module spi_cmd_master #(
    parameter int ADDR_SIZE = 8,
    parameter int RD_LAT    = 2,
    parameter int CS_GAP    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           cmd,
    input  logic [ADDR_SIZE-1:0] payload,
    output logic                 ready,
    output logic                 done,
    output logic                 rd_valid,
    output logic [ADDR_SIZE-1:0] rd_data,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
);

    localparam int FW  = ADDR_SIZE + 2;
    localparam int M1  = (FW > RD_LAT) ? FW : RD_LAT;
    localparam int M2  = (M1 > CS_GAP) ? M1 : CS_GAP;
    localparam int CW  = (M2 > 1) ? $clog2(M2) : 1;

    localparam logic [CW-1:0] SHIFT_LAST = CW'(FW - 1);
    localparam logic [CW-1:0] CAP_LAST   = CW'(ADDR_SIZE - 1);
    localparam logic [CW-1:0] WAIT_LAST  = CW'((RD_LAT > 0) ? RD_LAT - 1 : 0);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, SEL, SHIFT, TAIL, RD_WAIT, RD_CAP, GAP
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          cnt;
    logic [FW-1:0]          sreg;
    logic [ADDR_SIZE-2:0]   shadow;
    logic                   rd_flag;
    logic                   accept;

    // SS_n derives from the state register alone, so reset raises it asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        rd_valid   = 1'b0;
        SS_n       = 1'b0;
        MOSI       = 1'b0;
        unique case (state)
            IDLE: begin
                SS_n  = 1'b1;
                ready = 1'b1;
                if (start) state_next = SEL;
            end
            SEL: begin
                MOSI = (cnt == CW'(1)) ? sreg[FW-1] : 1'b0;
                if (cnt == CW'(1)) state_next = SHIFT;
            end
            SHIFT: begin
                MOSI = sreg[FW-1];
                if (cnt == SHIFT_LAST) begin
                    if (!rd_flag)        state_next = TAIL;
                    else if (RD_LAT > 0) state_next = RD_WAIT;
                    else                 state_next = RD_CAP;
                end
            end
            TAIL:    state_next = GAP;
            RD_WAIT: if (cnt == WAIT_LAST) state_next = RD_CAP;
            RD_CAP:  if (cnt == CAP_LAST)  state_next = GAP;
            GAP: begin
                SS_n     = 1'b1;
                done     = (cnt == '0);
                rd_valid = (cnt == '0) && rd_flag;
                // The last gap cycle already accepts, so frames sit exactly CS_GAP cycles apart.
                if (cnt == GAP_LAST) begin
                    ready      = 1'b1;
                    state_next = start ? SEL : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = start && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            sreg    <= '0;
            shadow  <= '0;
            rd_flag <= 1'b0;
            rd_data <= '0;
        end else begin
            if (state_next != state || state == IDLE) cnt <= '0;
            else                                      cnt <= cnt + 1'b1;

            if (accept) begin
                sreg    <= {cmd, payload};
                rd_flag <= (cmd == 2'b11);
            end else if (state == SHIFT) begin
                sreg <= {sreg[FW-2:0], 1'b0};
            end

            if (state == RD_CAP) begin
                shadow <= {shadow[ADDR_SIZE-3:0], MISO};
                if (cnt == CAP_LAST) rd_data <= {shadow, MISO};
            end
        end
    end

endmodule
